// File: rtl/cisc_pkg.sv
// Shared types and constants for the CISC memory arbiter: FSM states,
// requester grant identity and the data value returned on a bus timeout.
package cisc_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } gnt_t;

   localparam logic [15:0] ERR_RDATA = 16'hFFFF;

endpackage

// File: rtl/cisc_mem_arbiter_if.sv
// Requester and external-memory signals of the arbiter. The slave modport is
// the arbiter's view; the master modport is the requesters plus the memory.
interface cisc_mem_arbiter_if;

   logic        f_req;
   logic [15:0] f_addr;
   logic        f_done;
   logic [15:0] f_rdata;

   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_done;
   logic [15:0] d_rdata;

   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   logic        bus_err;
   logic        err_clr;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack, err_clr,
      output f_done, f_rdata, d_done, d_rdata, mem_addr, mem_wdata, mem_rd, mem_wr, bus_err
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack, err_clr,
      input  f_done, f_rdata, d_done, d_rdata, mem_addr, mem_wdata, mem_rd, mem_wr, bus_err
   );

endinterface

// File: rtl/cisc_mem_arbiter.sv
// Round-robin arbiter sharing one external memory bus between an instruction
// fetch port and a data port, with a per-access timeout and sticky error flag.
module cisc_mem_arbiter
   import cisc_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   cisc_mem_arbiter_if.slave         bus
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t      r_state;
   gnt_t        r_gnt;
   gnt_t        r_lastGnt;
   logic        r_we;
   logic [7:0]  r_waitCnt;
   logic [15:0] r_memAddr;
   logic [15:0] r_memWdata;
   logic        r_memRd;
   logic        r_memWr;
   logic        r_fDone;
   logic        r_dDone;
   logic [15:0] r_fRdata;
   logic [15:0] r_dRdata;
   logic        r_busErr;

   state_t      w_stateNext;
   gnt_t        w_gntNext;
   gnt_t        w_lastGntNext;
   gnt_t        w_pick;
   logic        w_weNext;
   logic [7:0]  w_waitCntNext;
   logic [7:0]  w_cntInc;
   logic [15:0] w_memAddrNext;
   logic [15:0] w_memWdataNext;
   logic        w_memRdNext;
   logic        w_memWrNext;
   logic        w_fDoneNext;
   logic        w_dDoneNext;
   logic [15:0] w_fRdataNext;
   logic [15:0] w_dRdataNext;
   logic        w_busErrNext;
   logic        w_isRead;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_gnt      <= FETCH;
         r_lastGnt  <= FETCH;
         r_we       <= 1'b0;
         r_waitCnt  <= 8'd0;
         r_memAddr  <= 16'h0000;
         r_memWdata <= 16'h0000;
         r_memRd    <= 1'b0;
         r_memWr    <= 1'b0;
         r_fDone    <= 1'b0;
         r_dDone    <= 1'b0;
         r_fRdata   <= 16'h0000;
         r_dRdata   <= 16'h0000;
         r_busErr   <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_gnt      <= w_gntNext;
         r_lastGnt  <= w_lastGntNext;
         r_we       <= w_weNext;
         r_waitCnt  <= w_waitCntNext;
         r_memAddr  <= w_memAddrNext;
         r_memWdata <= w_memWdataNext;
         r_memRd    <= w_memRdNext;
         r_memWr    <= w_memWrNext;
         r_fDone    <= w_fDoneNext;
         r_dDone    <= w_dDoneNext;
         r_fRdata   <= w_fRdataNext;
         r_dRdata   <= w_dRdataNext;
         r_busErr   <= w_busErrNext;
      end
   end

   // All outputs are registered, so the strobes and done pulses computed here
   // become visible one edge later; done is therefore high exactly while in DONE.
   always_comb begin
      w_stateNext    = r_state;
      w_gntNext      = r_gnt;
      w_lastGntNext  = r_lastGnt;
      w_pick         = FETCH;
      w_weNext       = r_we;
      w_waitCntNext  = r_waitCnt;
      w_cntInc       = r_waitCnt + 8'd1;
      w_memAddrNext  = r_memAddr;
      w_memWdataNext = r_memWdata;
      w_memRdNext    = 1'b0;
      w_memWrNext    = 1'b0;
      w_fDoneNext    = 1'b0;
      w_dDoneNext    = 1'b0;
      w_fRdataNext   = r_fRdata;
      w_dRdataNext   = r_dRdata;
      w_busErrNext   = r_busErr & ~bus.err_clr;
      w_isRead       = (r_gnt == FETCH) || !r_we;

      case (r_state)
         S_IDLE: begin
            if (bus.f_req || bus.d_req) begin
               // last_gnt only moves on contention, so a lone requester never steals the next tie
               if (bus.d_req && (!bus.f_req || r_lastGnt == FETCH)) begin
                  w_pick = DATA;
               end
               if (bus.f_req && bus.d_req) begin
                  w_lastGntNext = w_pick;
               end
               w_gntNext     = w_pick;
               w_waitCntNext = 8'd0;
               w_stateNext   = S_REQ;
               if (w_pick == DATA) begin
                  w_memAddrNext  = bus.d_addr;
                  w_memWdataNext = bus.d_wdata;
                  w_weNext       = bus.d_we;
                  w_memWrNext    = bus.d_we;
                  w_memRdNext    = !bus.d_we;
               end else begin
                  w_memAddrNext = bus.f_addr;
                  w_weNext      = 1'b0;
                  w_memRdNext   = 1'b1;
               end
            end
         end

         S_REQ: begin
            if (bus.mem_ack || w_cntInc == TIMEOUT_C) begin
               w_stateNext = S_DONE;
               w_fDoneNext = (r_gnt == FETCH);
               w_dDoneNext = (r_gnt == DATA);
               if (!bus.mem_ack) begin
                  w_busErrNext = 1'b1;
               end
               if (w_isRead) begin
                  if (r_gnt == FETCH) begin
                     w_fRdataNext = bus.mem_ack ? bus.mem_rdata : ERR_RDATA;
                  end else begin
                     w_dRdataNext = bus.mem_ack ? bus.mem_rdata : ERR_RDATA;
                  end
               end
            end else begin
               w_waitCntNext = w_cntInc;
               w_memRdNext   = r_memRd;
               w_memWrNext   = r_memWr;
            end
         end

         S_DONE: begin
            w_stateNext = S_IDLE;
         end

         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   assign bus.f_done    = r_fDone;
   assign bus.d_done    = r_dDone;
   assign bus.f_rdata   = r_fRdata;
   assign bus.d_rdata   = r_dRdata;
   assign bus.mem_addr  = r_memAddr;
   assign bus.mem_wdata = r_memWdata;
   assign bus.mem_rd    = r_memRd;
   assign bus.mem_wr    = r_memWr;
   assign bus.bus_err   = r_busErr;

endmodule

// File: doc/cisc_mem_arbiter.md
CISC_MEM_ARBITER -- requirements
Module: cisc_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: number of REQ-state cycles without mem_ack before the transaction is aborted; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 f_req  input  1  instruction-fetch read request; held high until f_done.
REQ-005 f_addr  input  16  fetch address.
REQ-006 f_done  output  1  one-cycle pulse; fetch complete, f_rdata valid.
REQ-007 f_rdata  output  16  fetched word, held until the next fetch completes.
REQ-008 d_req  input  1  data-access request; held high until d_done.
REQ-009 d_we  input  1  1 = write, 0 = read; sampled with d_req.
REQ-010 d_addr / d_wdata  input  16 / 16  data address / write data.
REQ-011 d_done  output  1  one-cycle pulse; data access complete.
REQ-012 d_rdata  output  16  read word, held until the next data read completes.
REQ-013 mem_addr / mem_wdata  output  16 / 16  external address bus / write data.
REQ-014 mem_rd / mem_wr  output  1 / 1  external read / write strobes, mutually exclusive.
REQ-015 mem_rdata / mem_ack  input  16 / 1  external read data / access-complete acknowledge.
REQ-016 bus_err  output  1  sticky timeout flag.
REQ-017 err_clr  input  1  synchronous clear of bus_err.

Function
REQ-018 FSM states: IDLE, REQ, DONE; encoding 2 bits.
REQ-019 IDLE: with no request, remain in IDLE with mem_rd = mem_wr = 0.
REQ-020 IDLE, one request high: grant that requester, latch its addr/we/wdata, go to REQ.
REQ-021 IDLE, both requests high: grant the requester not granted last (round-robin last_gnt bit), then update last_gnt.
REQ-022 last_gnt resets to FETCH, so data wins the first simultaneous request.
REQ-023 REQ: drive latched address on mem_addr; assert mem_rd (fetch, or data with we = 0) or mem_wr with mem_wdata (data with we = 1).
REQ-024 REQ: mem_ack sampled high -> capture mem_rdata into the granted requester's rdata register (reads only), then go to DONE.
REQ-025 REQ: an 8-bit wait counter clears on entry and increments each cycle without ack.
REQ-026 REQ: counter == TIMEOUT with no ack -> set bus_err, load rdata with 16'hFFFF (reads only), go to DONE.
REQ-027 mem_ack arriving in the same cycle the counter reaches TIMEOUT is a normal completion; no error.
REQ-028 DONE: pulse the granted requester's done for exactly one cycle, strobes low, go to IDLE.
REQ-029 Minimum latency is 3 cycles: req sampled in IDLE at edge N, strobe at N+1, ack at N+1, done high after N+2.
REQ-030 Requesters deassert req on the edge at which done is high; a req still high in IDLE starts a new transaction.
REQ-031 Deassertion of req or changes to addr/wdata during REQ are ignored; the latched transaction completes.
REQ-032 mem_ack outside REQ is ignored.
REQ-033 err_clr clears bus_err; a timeout in the same cycle wins (bus_err stays 1).
REQ-034 mem_addr, mem_wdata, f_rdata and d_rdata are registered; no combinational path from any input to any output.

Reset
REQ-035 rst low -> immediately: state = IDLE, mem_rd = mem_wr = 0, f_done = d_done = 0, bus_err = 0, last_gnt = FETCH, counter = 0.
REQ-036 rst low -> immediately: mem_addr, mem_wdata, f_rdata and d_rdata = 16'h0000.
REQ-037 Reset asserted mid-transaction abandons it; no done pulse is issued for it after reset release.

Structure
REQ-038 Shared package cisc_pkg holds: FSM state typedef, grant enum {FETCH, DATA}, and constant ERR_RDATA = 16'hFFFF.
REQ-039 The block is a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-040 Fetch-only test: f_addr = 16'h0010, mem_ack one cycle after mem_rd with mem_rdata = 16'h1234 -> f_done 3 cycles after f_req, f_rdata = 16'h1234.
REQ-041 Simultaneous-request test: f_req and d_req rise together after reset -> data granted first, fetch granted second; next simultaneous pair -> fetch first.
REQ-042 Data-write test: d_we = 1, d_addr = 16'h0200, d_wdata = 16'hBEEF, ack after 4 wait cycles -> mem_wr high for 5 cycles with stable bus values, then one d_done pulse.
REQ-043 Timeout test: TIMEOUT = 15, ack never asserted -> DONE after 15 REQ cycles, d_rdata = 16'hFFFF, bus_err = 1 until err_clr.
REQ-044 Reset-mid-REQ test: rst low during REQ -> strobes drop asynchronously; no done pulse after release; the next request completes normally.
REQ-045 Boundary tests: ack coincident with counter = TIMEOUT -> no error; stray mem_ack in IDLE -> no state change.
